tx_frame_arbiter: RTL and testbench

- Round-robin scheduler sharing the single MAC TX byte path between NUM_Q per-source transmit FIFOs (non-FWFT, registered dout, 1-cycle read latency, each entry carries a last-byte flag).
- Grants one queue per frame and drains that frame byte-by-byte into the MAC with valid/ready backpressure.
- Enforces an inter-frame gap between frames, then re-arbitrates.

---
 rtl/tx_frame_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that drains one frame at a time from NUM_Q non-FWFT transmit FIFOs
// into a single MAC byte stream, inserting a fixed inter-frame gap between frames.
module tx_frame_arbiter #(
    parameter int unsigned NUM_Q      = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NUM_Q-1:0]         q_empty,
    output logic [NUM_Q-1:0]         q_rd_en,
    input  logic [NUM_Q*WIDTH-1:0]   q_data,
    input  logic [NUM_Q-1:0]         q_last,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_valid,
    output logic                     tx_last,
    input  logic                     tx_ready,
    output logic [$clog2(NUM_Q)-1:0] grant_id,
    output logic                     busy
);

    localparam int unsigned GW      = $clog2(NUM_Q);
    localparam logic [7:0]  IfgLoad = 8'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StXfer, StFlush, StIfg} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [1:0][WIDTH-1:0]  buf_data_q, buf_data_d;
    logic [1:0]             buf_last_q, buf_last_d;
    logic                   head_q, head_d;
    logic                   tail_q, tail_d;
    logic [1:0]             count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic [7:0]             ifg_q, ifg_d;

    logic                   sel_empty;
    logic                   sel_last;
    logic [WIDTH-1:0]       sel_data;
    logic                   found;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          cand;
    logic                   push;
    logic                   pop;
    logic [2:0]             level;
    logic                   space_ok;
    logic                   rd_go;

    // Granted queue's FIFO signals
    always_comb begin
        sel_empty = 1'b1;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            if (grant_q == GW'(i)) begin
                sel_empty = q_empty[i];
                sel_last  = q_last[i];
                sel_data  = q_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // First non-empty queue searching ptr+1, ptr+2, ... wrapping back to ptr itself
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int unsigned k = 1; k <= NUM_Q; k++) begin
            cand = GW'((32'(ptr_q) + k) % NUM_Q);
            if (!found && !q_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        tx_valid = (count_q != 2'd0);
        tx_data  = tx_valid ? buf_data_q[head_q] : '0;
        tx_last  = tx_valid & buf_last_q[head_q];
        pop      = tx_valid & tx_ready;
        push     = inflight_q;
        level    = {1'b0, count_q} + {2'b00, inflight_q};
        // Reserve a slot for every read still in flight so the buffer can never overflow
        space_ok = level < (3'd2 + {2'b00, pop});
        rd_go    = (state_q == StXfer) & ~sel_empty & ~(inflight_q & sel_last) & space_ok;
        grant_id = grant_q;
        busy     = (state_q != StIdle);
    end

    always_comb begin
        q_rd_en = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            q_rd_en[i] = rd_go && (grant_q == GW'(i));
        end
    end

    // Two-entry in-order output buffer fed by the FIFO's registered dout
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (push) begin
            buf_data_d[tail_q] = sel_data;
            buf_last_d[tail_q] = sel_last;
            tail_d             = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        ifg_d      = ifg_q;
        inflight_d = rd_go;
        case (state_q)
            StIdle: begin
                if (arb_en && found) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (push && sel_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (pop && tx_last) begin
                    state_d = StIfg;
                    ifg_d   = IfgLoad;
                end
            end
            StIfg: begin
                if (ifg_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= GW'(NUM_Q - 1);
            grant_q    <= '0;
            buf_data_q <= '0;
            buf_last_q <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            ifg_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ifg_q      <= ifg_d;
        end
    end

    a_rd_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(q_rd_en));
    a_rd_nonempty: assert property (@(posedge clk) disable iff (rst)
        (q_rd_en != '0) |-> !sel_empty);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(count_q == 2'd2 && inflight_q));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data) && $stable(tx_last)));

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: FIFO models feed the DUT, expected bytes are queued
// when frames are loaded and checked as the MAC side accepts them.
module tb_tx_frame_arbiter;

    localparam int unsigned NQ  = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IFG = 12;

    typedef struct packed {
        logic [1:0] q;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            arb_en;
    logic [NQ-1:0]   q_empty;
    logic [NQ-1:0]   q_rd_en;
    logic [NQ*W-1:0] q_data;
    logic [NQ-1:0]   q_last;
    logic [W-1:0]    tx_data;
    logic            tx_valid;
    logic            tx_last;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    tx_frame_arbiter #(
        .NUM_Q     (NQ),
        .WIDTH     (W),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (arb_en),
        .q_empty (q_empty),
        .q_rd_en (q_rd_en),
        .q_data  (q_data),
        .q_last  (q_last),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .grant_id(grant_id),
        .busy    (busy)
    );

    logic [8:0] fifo [NQ][$];
    exp_t       exp_q[$];
    int         gaps[$];
    int         frame_lens[$];

    int   n_total, n_bad, cyc;
    int   bytes, lasts, rd_pulses, rd_viol, rd_empty_err, valid_cnt;
    int   gap_cnt, start_cyc, rd_at_first_last;
    bit   counting, in_frame, hold_pending, bp_mode;
    logic [8:0] held;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic clear_stats();
        bytes = 0; lasts = 0; rd_pulses = 0; rd_viol = 0; rd_empty_err = 0; valid_cnt = 0;
        gap_cnt = 0; start_cyc = 0; rd_at_first_last = -1;
        counting = 1'b0; in_frame = 1'b0; hold_pending = 1'b0; held = '0;
        gaps.delete();
        frame_lens.delete();
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < NQ; i++) q_empty[i] = (fifo[i].size() == 0);
    endtask

    task automatic fifo_put(input int q, input logic [7:0] data, input logic last);
        fifo[q].push_back({last, data});
        refresh_empty();
    endtask

    task automatic exp_put(input int q, input logic [7:0] data, input logic last);
        exp_t e;
        e.q = 2'(q);
        e.last = last;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // MAC-side monitor, called once per cycle at the falling edge
    task automatic sample();
        exp_t          e;
        logic [NQ-1:0] one;
        one = '0;
        one[grant_id] = 1'b1;
        if (q_rd_en != '0) rd_pulses++;
        if (q_rd_en != '0 && q_rd_en != one) rd_viol++;
        if (tx_valid) valid_cnt++;
        if (hold_pending) begin
            check_eq("hold_valid", 32'(tx_valid), 32'(1));
            check_eq("hold_data", 32'({tx_last, tx_data}), 32'(held));
        end
        if (counting) begin
            if (busy && !tx_valid) gap_cnt++;
            else begin
                gaps.push_back(gap_cnt);
                counting = 1'b0;
            end
        end
        if (tx_valid && tx_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("byte_grant", 32'(grant_id), 32'(e.q));
                check_eq("byte_data", 32'(tx_data), 32'(e.data));
                check_eq("byte_last", 32'(tx_last), 32'(e.last));
            end
            if (!in_frame) begin
                in_frame = 1'b1;
                start_cyc = cyc;
            end
            bytes++;
            if (tx_last) begin
                lasts++;
                in_frame = 1'b0;
                frame_lens.push_back(cyc - start_cyc + 1);
                counting = 1'b1;
                gap_cnt = 0;
                if (lasts == 1) rd_at_first_last = rd_pulses;
            end
        end
        hold_pending = tx_valid && !tx_ready;
        held = {tx_last, tx_data};
    endtask

    // One clock: monitor, then FIFO model (registered dout, 1-cycle latency), then new inputs
    task automatic tick();
        logic [NQ-1:0] rd_snap;
        logic [8:0]    ent;
        @(negedge clk);
        sample();
        rd_snap = q_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NQ; i++) begin
            if (rd_snap[i]) begin
                if (fifo[i].size() == 0) rd_empty_err++;
                else begin
                    ent = fifo[i].pop_front();
                    q_data[i*W +: W] = ent[7:0];
                    q_last[i] = ent[8];
                end
            end
        end
        refresh_empty();
        tx_ready = bp_mode ? ($urandom_range(0, 99) < 55) : 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NQ; i++) fifo[i].delete();
        refresh_empty();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            tick();
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n < limit), 32'(1));
        tick();
    endtask

    task automatic check_clean(input string tag);
        check_eq({tag, "_rd_viol"}, 32'(rd_viol), 32'(0));
        check_eq({tag, "_rd_empty"}, 32'(rd_empty_err), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad_gaps;
        rst = 1'b1; arb_en = 1'b1; q_empty = '1; q_data = '0; q_last = '0;
        tx_ready = 1'b1; bp_mode = 1'b0;
        n_total = 0; n_bad = 0; cyc = 0;
        clear_stats();

        // Single 5-byte frame on queue 2
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_valid", 32'(tx_valid), 32'(0));
        check_eq("rst_last", 32'(tx_last), 32'(0));
        check_eq("rst_data", 32'(tx_data), 32'(0));
        check_eq("rst_grant", 32'(grant_id), 32'(0));
        check_eq("rst_rd_en", 32'(q_rd_en), 32'(0));
        for (int k = 0; k < 5; k++) begin
            fifo_put(2, 8'(8'h11 + k), k == 4);
            exp_put(2, 8'(8'h11 + k), k == 4);
        end
        drain("t1", 200);
        check_eq("t1_bytes", 32'(bytes), 32'(5));
        check_eq("t1_lasts", 32'(lasts), 32'(1));
        check_eq("t1_grant", 32'(grant_id), 32'(2));
        check_eq("t1_len", 32'(frame_lens.size() > 0 ? frame_lens[0] : -1), 32'(5));
        check_eq("t1_gap", 32'(gaps.size() > 0 ? gaps[0] : -1), 32'(IFG));
        check_eq("t1_busy_end", 32'(busy), 32'(0));
        check_clean("t1");

        // Round-robin: two 3-byte frames per queue
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int q = 0; q < NQ; q++)
                for (int k = 0; k < 3; k++) begin
                    fifo_put(q, 8'(8'h40 + q*16 + f*4 + k), k == 2);
                    exp_put(q, 8'(8'h40 + q*16 + f*4 + k), k == 2);
                end
        drain("t2", 800);
        check_eq("t2_bytes", 32'(bytes), 32'(24));
        check_eq("t2_lasts", 32'(lasts), 32'(8));
        check_eq("t2_ngaps", 32'(gaps.size()), 32'(8));
        bad_gaps = 0;
        foreach (gaps[i]) if (gaps[i] != IFG) bad_gaps++;
        check_eq("t2_gaps", 32'(bad_gaps), 32'(0));
        check_clean("t2");

        // 64-byte frame under random backpressure
        do_reset();
        for (int k = 0; k < 64; k++) begin
            fifo_put(3, 8'(k*7 + 3), k == 63);
            exp_put(3, 8'(k*7 + 3), k == 63);
        end
        bp_mode = 1'b1;
        drain("t3", 3000);
        bp_mode = 1'b0;
        tx_ready = 1'b1;
        check_eq("t3_bytes", 32'(bytes), 32'(64));
        check_eq("t3_lasts", 32'(lasts), 32'(1));
        check_eq("t3_reads", 32'(rd_pulses), 32'(64));
        check_clean("t3");

        // Underrun on queue 1 with queue 2 pending
        do_reset();
        for (int k = 0; k < 3; k++) fifo_put(1, 8'(8'hA0 + k), 1'b0);
        for (int k = 0; k < 6; k++) exp_put(1, 8'(8'hA0 + k), k == 5);
        for (int k = 0; k < 4; k++) begin
            fifo_put(2, 8'(8'hC0 + k), k == 3);
            exp_put(2, 8'(8'hC0 + k), k == 3);
        end
        repeat (10) tick();
        valid_cnt = 0;
        repeat (20) tick();
        check_eq("t4_partial", 32'(bytes), 32'(3));
        check_eq("t4_stall_valid", 32'(valid_cnt), 32'(0));
        check_eq("t4_stall_grant", 32'(grant_id), 32'(1));
        check_eq("t4_stall_busy", 32'(busy), 32'(1));
        for (int k = 3; k < 6; k++) fifo_put(1, 8'(8'hA0 + k), k == 5);
        drain("t4", 300);
        check_eq("t4_bytes", 32'(bytes), 32'(10));
        check_eq("t4_lasts", 32'(lasts), 32'(2));
        check_clean("t4");

        // arb_en dropped mid-frame
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fifo_put(0, 8'(8'h50 + k), k == 3);
            exp_put(0, 8'(8'h50 + k), k == 3);
        end
        for (int k = 0; k < 3; k++) fifo_put(1, 8'(8'h60 + k), k == 2);
        n = 0;
        while (bytes == 0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("t5a_start_timeout", 32'(n < 50), 32'(1));
        arb_en = 1'b0;
        drain("t5a", 200);
        repeat (20) tick();
        check_eq("t5a_bytes", 32'(bytes), 32'(4));
        check_eq("t5a_lasts", 32'(lasts), 32'(1));
        check_eq("t5a_idle", 32'(busy), 32'(0));
        check_eq("t5a_q1_held", 32'(fifo[1].size()), 32'(3));
        for (int k = 0; k < 3; k++) exp_put(1, 8'(8'h60 + k), k == 2);
        arb_en = 1'b1;
        drain("t5a_resume", 200);
        check_eq("t5a_bytes_all", 32'(bytes), 32'(7));
        check_clean("t5a");

        // Reset on byte 4 of a 10-byte frame
        do_reset();
        for (int k = 0; k < 10; k++) begin
            fifo_put(2, 8'(8'h80 + k), k == 9);
            exp_put(2, 8'(8'h80 + k), k == 9);
        end
        n = 0;
        while (bytes < 3 && n < 50) begin
            tick();
            n++;
        end
        check_eq("t5b_start_timeout", 32'(n < 50), 32'(1));
        check_eq("t5b_byte4", 32'(tx_data), 32'(8'h83));
        rst = 1'b1;
        tick();
        check_eq("t5b_busy", 32'(busy), 32'(0));
        check_eq("t5b_valid", 32'(tx_valid), 32'(0));
        check_eq("t5b_last", 32'(tx_last), 32'(0));
        check_eq("t5b_data", 32'(tx_data), 32'(0));
        check_eq("t5b_grant", 32'(grant_id), 32'(0));
        check_eq("t5b_rd_en", 32'(q_rd_en), 32'(0));
        rst = 1'b0;
        fifo[2].delete();
        refresh_empty();
        exp_q.delete();
        clear_stats();
        for (int k = 0; k < 2; k++) begin
            fifo_put(0, 8'(8'h90 + k), k == 1);
            fifo_put(3, 8'(8'hB0 + k), k == 1);
        end
        for (int k = 0; k < 2; k++) exp_put(0, 8'(8'h90 + k), k == 1);
        for (int k = 0; k < 2; k++) exp_put(3, 8'(8'hB0 + k), k == 1);
        drain("t5b", 300);
        check_eq("t5b_bytes", 32'(bytes), 32'(4));
        check_eq("t5b_lasts", 32'(lasts), 32'(2));
        check_clean("t5b");

        // 1-byte frame followed by a queued 2-byte frame on the same queue
        do_reset();
        fifo_put(1, 8'hE5, 1'b1);
        exp_put(1, 8'hE5, 1'b1);
        fifo_put(1, 8'hE6, 1'b0);
        exp_put(1, 8'hE6, 1'b0);
        fifo_put(1, 8'hE7, 1'b1);
        exp_put(1, 8'hE7, 1'b1);
        drain("t6", 300);
        check_eq("t6_reads_first", 32'(rd_at_first_last), 32'(1));
        check_eq("t6_bytes", 32'(bytes), 32'(3));
        check_eq("t6_lasts", 32'(lasts), 32'(2));
        check_eq("t6_reads", 32'(rd_pulses), 32'(3));
        check_clean("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
